sprite_ram_writer: RTL and testbench

- Write-side companion to the sprite/character ROM sweep reader: loads a WIDTH x HEIGHT sprite memory that the reader later scans.
- Accepts a valid/ready pixel stream of (x, y, data), computes the linear address y*WIDTH + x, and drives a registered single-port write interface.
- Also provides a hardware clear that sweeps every address with a fill value.
- Sits between the sprite loader/game logic and the sprite RAM write port.

---
 rtl/sprite_ram_writer.sv | 138 +++++++++++++
 tb/tb_sprite_ram_writer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_ram_writer.sv
// Sprite RAM write-side controller: maps (x, y) pixels to y*WIDTH+x writes, one cycle after handshake.
// Hardware clear sweeps every address with a latched fill value; pixel input is held off while clearing.
module sprite_ram_writer #(
  parameter int WIDTH   = 5,
  parameter int HEIGHT  = 5,
  parameter int COORD_W = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pix_valid,
  output logic                pix_ready,
  input  logic [COORD_W-1:0]  pix_x,
  input  logic [COORD_W-1:0]  pix_y,
  input  logic [DATA_W-1:0]   pix_data,
  input  logic                clear_req,
  input  logic [DATA_W-1:0]   clear_data,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_data,
  output logic                busy,
  output logic                done,
  output logic                oob,
  output logic [ADDR_W:0]     write_count
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [31:0]        WIDTH_U  = 32'(WIDTH);
  localparam logic [31:0]        HEIGHT_U = 32'(HEIGHT);
  localparam logic [ADDR_W-1:0]  WIDTH_A  = ADDR_W'(WIDTH);
  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(HEIGHT - 1);

  state_t               state_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_address_q;
  logic [DATA_W-1:0]    mem_data_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 oob_q;
  logic [ADDR_W:0]      write_count_q;
  logic [COORD_W-1:0]   x_q;
  logic [COORD_W-1:0]   y_q;
  logic [DATA_W-1:0]    fill_q;

  logic                 pix_in_bounds;
  logic [ADDR_W-1:0]    pix_addr;
  logic [ADDR_W-1:0]    clr_addr;

  // Bounds compared at 32 bits so a coordinate equal to WIDTH/HEIGHT is never aliased.
  assign pix_in_bounds = (32'(pix_x) < WIDTH_U) && (32'(pix_y) < HEIGHT_U);
  assign pix_addr      = ADDR_W'(pix_y) * WIDTH_A + ADDR_W'(pix_x);
  assign clr_addr      = ADDR_W'(y_q) * WIDTH_A + ADDR_W'(x_q);

  assign pix_ready = (state_q == ST_IDLE) && !clear_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      mem_we_q      <= 1'b0;
      mem_address_q <= '0;
      mem_data_q    <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      oob_q         <= 1'b0;
      write_count_q <= '0;
      x_q           <= '0;
      y_q           <= '0;
      fill_q        <= '0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      oob_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            fill_q  <= clear_data;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_CLEAR;
          end else if (pix_valid) begin
            if (pix_in_bounds) begin
              mem_we_q      <= 1'b1;
              mem_address_q <= pix_addr;
              mem_data_q    <= pix_data;
              if (write_count_q != '1) begin
                write_count_q <= write_count_q + 1'b1;
              end
            end else begin
              oob_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          mem_we_q      <= 1'b1;
          mem_address_q <= clr_addr;
          mem_data_q    <= fill_q;
          // x is the inner loop; the final (X_LAST, Y_LAST) write ends the sweep.
          if (x_q == X_LAST) begin
            x_q <= '0;
            if (y_q == Y_LAST) begin
              busy_q  <= 1'b0;
              state_q <= ST_DONE;
            end else begin
              y_q <= y_q + 1'b1;
            end
          end else begin
            x_q <= x_q + 1'b1;
          end
        end
        ST_DONE: begin
          done_q        <= 1'b1;
          write_count_q <= '0;
          state_q       <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_address = mem_address_q;
  assign mem_data    = mem_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign oob         = oob_q;
  assign write_count = write_count_q;

endmodule

// File: tb/tb_sprite_ram_writer.sv
// Bench for sprite_ram_writer: scoreboard of expected RAM writes plus per-scenario inline checks.
module tb_sprite_ram_writer;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic        pix_ready;
  logic [3:0]  pix_x;
  logic [3:0]  pix_y;
  logic [7:0]  pix_data;
  logic        clear_req;
  logic [7:0]  clear_data;
  logic        mem_we;
  logic [9:0]  mem_address;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;
  logic        oob;
  logic [10:0] write_count;

  int checks = 0;
  int errors = 0;
  int oob_cnt = 0;
  int done_cnt = 0;
  int exp_wc = 0;
  wr_t sb[$];

  sprite_ram_writer #(
    .WIDTH(5), .HEIGHT(5), .COORD_W(4), .ADDR_W(10), .DATA_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .clear_req(clear_req), .clear_data(clear_data),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data(mem_data),
    .busy(busy), .done(done), .oob(oob), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // Every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (oob) oob_cnt++;
    if (done) done_cnt++;
    if (mem_we) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected addr=%0d data=%h", mem_address, mem_data);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if ({mem_address, mem_data} !== e) begin
          errors++;
          $display("FAIL sb_write got addr=%0d data=%h exp addr=%0d data=%h",
                   mem_address, mem_data, e.a, e.d);
        end
      end
    end
  end

  function automatic void push_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 10'(a);
    e.d = d;
    sb.push_back(e);
  endfunction

  task automatic drive_pix(input int x, input int y, input logic [7:0] d);
    pix_valid = 1'b1;
    pix_x     = 4'(x);
    pix_y     = 4'(y);
    pix_data  = d;
    if (x < 5 && y < 5) begin
      push_wr(y * 5 + x, d);
      exp_wc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mem_we, busy, done, oob} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {mem_we, busy, done, oob});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_address !== 10'd0 || mem_data !== 8'd0) begin
      errors++;
      $display("FAIL reset_addr_data got=%0d/%h exp=0/00", mem_address, mem_data);
    end
    checks++;
    if (write_count !== 11'd0) begin
      errors++;
      $display("FAIL reset_wc got=%0d exp=0", write_count);
    end
    checks++;
    if (pix_ready !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ready=%b we=%b exp ready=1 we=0", pix_ready, mem_we);
    end
  endtask

  task automatic test_single_pixel();
    @(posedge clk); #1;
    drive_pix(3, 2, 8'hA5);
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_ready got=%b exp=1", pix_ready);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_address !== 10'd13 || mem_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_write got we=%b addr=%0d data=%h exp we=1 addr=13 data=a5",
               mem_we, mem_address, mem_data);
    end
    checks++;
    if (write_count !== 11'(exp_wc) || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_wc got wc=%0d ready=%b exp wc=%0d ready=1",
               write_count, pix_ready, exp_wc);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    drive_pix(0, 4, 8'h40);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i < 4) drive_pix(i + 1, 4, 8'(8'h40 + i + 1));
      else pix_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || mem_address !== 10'(20 + i)) begin
        errors++;
        $display("FAIL b2b_beat%0d got we=%b addr=%0d exp we=1 addr=%0d",
                 i, mem_we, mem_address, 20 + i);
      end
    end
    checks++;
    if (write_count !== 11'(exp_wc)) begin
      errors++;
      $display("FAIL b2b_wc got=%0d exp=%0d", write_count, exp_wc);
    end
  endtask

  task automatic test_oob();
    int oob0;
    oob0 = oob_cnt;
    @(posedge clk); #1;
    drive_pix(5, 0, 8'hEE);
    @(posedge clk); #1;
    drive_pix(0, 7, 8'hDD);
    @(negedge clk);
    checks++;
    if (oob !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL oob_first got oob=%b we=%b exp oob=1 we=0", oob, mem_we);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (oob_cnt - oob0 !== 2 || oob !== 1'b0) begin
      errors++;
      $display("FAIL oob_pulses got=%0d exp=2", oob_cnt - oob0);
    end
    checks++;
    if (write_count !== 11'(exp_wc) || mem_address !== 10'd24) begin
      errors++;
      $display("FAIL oob_hold got wc=%0d addr=%0d exp wc=%0d addr=24",
               write_count, mem_address, exp_wc);
    end
  endtask

  task automatic test_clear();
    int busy_n = 0;
    int we_n = 0;
    int done0;
    done0 = done_cnt;
    @(posedge clk); #1;
    clear_req  = 1'b1;
    clear_data = 8'h1F;
    for (int a = 0; a < 25; a++) push_wr(a, 8'h1F);
    @(posedge clk); #1;
    clear_req = 1'b0;
    repeat (35) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (mem_we) we_n++;
    end
    exp_wc = 0;
    checks++;
    if (busy_n !== 25 || we_n !== 25) begin
      errors++;
      $display("FAIL clear_len got busy=%0d we=%0d exp 25/25", busy_n, we_n);
    end
    checks++;
    if (done_cnt - done0 !== 1) begin
      errors++;
      $display("FAIL clear_done got=%0d exp=1", done_cnt - done0);
    end
    checks++;
    if (write_count !== 11'd0 || pix_ready !== 1'b1 || sb.size() !== 0) begin
      errors++;
      $display("FAIL clear_end got wc=%0d ready=%b pending=%0d exp 0/1/0",
               write_count, pix_ready, sb.size());
    end
  endtask

  task automatic test_clear_priority();
    int waited = 0;
    @(posedge clk); #1;
    clear_req  = 1'b1;
    clear_data = 8'h3C;
    pix_valid  = 1'b1;
    pix_x      = 4'd1;
    pix_y      = 4'd0;
    pix_data   = 8'h77;
    for (int a = 0; a < 25; a++) push_wr(a, 8'h3C);
    @(negedge clk);
    checks++;
    if (pix_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready got=%b exp=0", pix_ready);
    end
    @(posedge clk); #1;
    clear_req = 1'b0;
    exp_wc = 0;
    drive_pix(2, 3, 8'h77);
    while (waited < 40) begin
      @(negedge clk);
      if (pix_ready) break;
      waited++;
    end
    checks++;
    if (waited !== 26) begin
      errors++;
      $display("FAIL prio_wait got=%0d cycles exp=26", waited);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_address !== 10'd17 || write_count !== 11'(exp_wc)) begin
      errors++;
      $display("FAIL prio_pixel got we=%b addr=%0d wc=%0d exp we=1 addr=17 wc=%0d",
               mem_we, mem_address, write_count, exp_wc);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n = 0;
    int guard = 0;
    int done0;
    @(posedge clk); #1;
    clear_req  = 1'b1;
    clear_data = 8'h55;
    for (int a = 0; a < 10; a++) push_wr(a, 8'h55);
    @(posedge clk); #1;
    clear_req = 1'b0;
    while (n < 10 && guard < 40) begin
      @(negedge clk);
      if (mem_we) n++;
      guard++;
    end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL mid_writes got=%0d exp=10", n);
    end
    done0 = done_cnt;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || write_count !== 11'd0) begin
      errors++;
      $display("FAIL mid_reset got we=%b busy=%b wc=%0d exp 0/0/0", mem_we, busy, write_count);
    end
    exp_wc = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== done0 || busy !== 1'b0 || pix_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after got done=%0d busy=%b ready=%b exp done=%0d busy=0 ready=1",
               done_cnt, busy, pix_ready, done0);
    end
    @(posedge clk); #1;
    drive_pix(1, 1, 8'h66);
    @(posedge clk); #1;
    pix_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_address !== 10'd6 || write_count !== 11'(exp_wc)) begin
      errors++;
      $display("FAIL mid_pixel got we=%b addr=%0d wc=%0d exp we=1 addr=6 wc=%0d",
               mem_we, mem_address, write_count, exp_wc);
    end
  endtask

  initial begin
    reset      = 1'b1;
    pix_valid  = 1'b0;
    pix_x      = '0;
    pix_y      = '0;
    pix_data   = '0;
    clear_req  = 1'b0;
    clear_data = '0;
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_oob();
    test_clear();
    test_clear_priority();
    test_reset_mid_clear();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
